// File: rtl/uart_pkg.sv
// Shared UART types and helpers used by both the transmit and receive sides.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int CLKS_PER_BIT_DEF = 16;

   function automatic logic parity_calc(input byte b, input logic odd);
      return (^b) ^ odd;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Clock-per-bit counter: restarts on clr and at every terminal count.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic n_rst,
   input  logic clr,
   output logic term
);

   localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign term = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (clr || term) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, LSB first,
// optional parity, one or two stop bits, all outputs registered.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter bit PARITY_EN    = 1'b0,
   parameter bit PARITY_ODD   = 1'b0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       valid_in,
   input  logic [7:0] data_in,
   output logic       ready_out,
   output logic       tx,
   output logic       done_out
);

   localparam logic STOP_LAST = 1'(STOP_BITS - 1);

   uart_state_t state_q, state_d;
   logic        tx_q, tx_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [2:0]  bit_q, bit_d;
   logic        stop_q, stop_d;
   logic        par_q, par_d;
   logic        clr;
   logic        term;

   // Counter is held at zero while idle so the start bit gets a full period.
   assign clr = (state_q == IDLE);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .n_rst(n_rst),
      .clr  (clr),
      .term (term)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      par_d   = par_q;
      case (state_q)
         IDLE: begin
            tx_d    = 1'b1;
            ready_d = 1'b1;
            if (valid_in && ready_q) begin
               state_d = START;
               tx_d    = 1'b0;
               ready_d = 1'b0;
               shreg_d = data_in;
               par_d   = parity_calc(data_in, PARITY_ODD);
               bit_d   = 3'd0;
            end
         end
         START: begin
            if (term) begin
               state_d = DATA;
               tx_d    = shreg_q[0];
            end
         end
         DATA: begin
            if (term) begin
               if (bit_q == 3'd7) begin
                  if (PARITY_EN) begin
                     state_d = PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = STOP;
                     tx_d    = 1'b1;
                     stop_d  = 1'b0;
                  end
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  tx_d    = shreg_q[1];
               end
            end
         end
         PARITY: begin
            if (term) begin
               state_d = STOP;
               tx_d    = 1'b1;
               stop_d  = 1'b0;
            end
         end
         STOP: begin
            if (term) begin
               if (stop_q == STOP_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         tx_q    <= 1'b1;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         shreg_q <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         par_q   <= par_d;
      end
   end

   assign tx        = tx_q;
   assign ready_out = ready_q;
   assign done_out  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations checked every cycle against a
// frame-level model, plus literal expectations for known frames.
module tb_uart_tx;

   localparam int N = 3;

   function automatic int f_cpb(input int i);
      return (i == 1) ? 4 : 16;
   endfunction
   function automatic int f_pen(input int i);
      return (i != 0) ? 1 : 0;
   endfunction
   function automatic int f_odd(input int i);
      return (i == 2) ? 1 : 0;
   endfunction
   function automatic int f_stp(input int i);
      return (i == 1) ? 2 : 1;
   endfunction
   function automatic int f_tot(input int i);
      return (9 + f_pen(i) + f_stp(i)) * f_cpb(i);
   endfunction

   logic         clk = 1'b0;
   logic         n_rst = 1'b0;
   logic [N-1:0] valid = '0;
   logic [N-1:0] rdy;
   logic [N-1:0] txl;
   logic [N-1:0] done;
   logic [7:0]   data_a [N];

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(16)) u0 (
      .clk(clk), .n_rst(n_rst), .valid_in(valid[0]), .data_in(data_a[0]),
      .ready_out(rdy[0]), .tx(txl[0]), .done_out(done[0]));
   uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
      .STOP_BITS(2)) u1 (
      .clk(clk), .n_rst(n_rst), .valid_in(valid[1]), .data_in(data_a[1]),
      .ready_out(rdy[1]), .tx(txl[1]), .done_out(done[1]));
   uart_tx #(.CLKS_PER_BIT(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b1),
      .STOP_BITS(1)) u2 (
      .clk(clk), .n_rst(n_rst), .valid_in(valid[2]), .data_in(data_a[2]),
      .ready_out(rdy[2]), .tx(txl[2]), .done_out(done[2]));

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Frame as a bit list: start, data LSB first, optional parity, stops.
   function automatic logic [15:0] mk_frame(input int i, input logic [7:0] d);
      logic [15:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int b = 0; b < 8; b++) f[1+b] = d[b];
      if (f_pen(i) != 0)
         f[9] = ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ (f_odd(i) != 0);
      return f;
   endfunction

   logic [N-1:0] m_busy = '0;
   logic [N-1:0] e_tx = '1;
   logic [N-1:0] e_rdy = '1;
   logic [N-1:0] e_done = '0;
   int           m_cyc [N];
   logic [15:0]  m_frame [N];

   always @(posedge clk or negedge n_rst) begin
      for (int i = 0; i < N; i++) begin
         if (!n_rst) begin
            m_busy[i] <= 1'b0;
            m_cyc[i]  <= 0;
            e_tx[i]   <= 1'b1;
            e_rdy[i]  <= 1'b1;
            e_done[i] <= 1'b0;
         end else if (!m_busy[i]) begin
            e_done[i] <= 1'b0;
            if (valid[i]) begin
               m_busy[i]  <= 1'b1;
               m_cyc[i]   <= 0;
               m_frame[i] <= mk_frame(i, data_a[i]);
               e_tx[i]    <= 1'b0;
               e_rdy[i]   <= 1'b0;
            end else begin
               e_tx[i]  <= 1'b1;
               e_rdy[i] <= 1'b1;
            end
         end else if (m_cyc[i] + 1 == f_tot(i)) begin
            m_busy[i] <= 1'b0;
            e_tx[i]   <= 1'b1;
            e_rdy[i]  <= 1'b1;
            e_done[i] <= 1'b1;
         end else begin
            m_cyc[i] <= m_cyc[i] + 1;
            e_tx[i]  <= m_frame[i][(m_cyc[i] + 1) / f_cpb(i)];
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         chk($sformatf("tx%0d", i), int'(txl[i]), int'(e_tx[i]));
         chk($sformatf("ready%0d", i), int'(rdy[i]), int'(e_rdy[i]));
         chk($sformatf("done%0d", i), int'(done[i]), int'(e_done[i]));
      end
   end

   int cyc = 0;
   int acc_cnt [N] = '{0, 0, 0};
   int acc_cyc [$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < N; i++) begin
         if (n_rst && valid[i] && rdy[i]) begin
            acc_cnt[i] <= acc_cnt[i] + 1;
            if (i == 0) acc_cyc.push_back(cyc);
         end
      end
   end

   task automatic send(input int i, input logic [7:0] b, input bit junk,
                       output logic [15:0] cap, output int len);
      int n;
      int jk;
      cap = '1;
      len = -1;
      jk  = f_tot(i) / 4;
      @(negedge clk);
      n = 0;
      while (!rdy[i] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) chk($sformatf("ready_wait%0d", i), 0, 1);
      valid[i]  = 1'b1;
      data_a[i] = b;
      @(negedge clk);
      valid[i]  = 1'b0;
      data_a[i] = 8'($urandom);
      for (int k = 0; k < 1000; k++) begin
         if (done[i]) begin
            len = k;
            break;
         end
         if ((k % f_cpb(i)) == f_cpb(i) / 2 && k / f_cpb(i) < 16)
            cap[k / f_cpb(i)] = txl[i];
         if (junk && k == jk) begin
            valid[i]  = 1'b1;
            data_a[i] = 8'h11;
         end
         if (junk && k == jk + 1) begin
            valid[i]  = 1'b0;
            data_a[i] = 8'($urandom);
         end
         @(negedge clk);
      end
   endtask

   task automatic rnd_run(input int i);
      logic [15:0] cap;
      int          len;
      for (int r = 0; r < 5; r++) begin
         repeat ($urandom_range(0, 7)) @(negedge clk);
         send(i, 8'($urandom), 1'($urandom_range(0, 1)), cap, len);
         chk($sformatf("rnd_len%0d", i), len, f_tot(i));
      end
   endtask

   initial begin
      logic [15:0] cap;
      int          len;
      int          qs;
      int          a0;
      int          n;
      for (int i = 0; i < N; i++) data_a[i] = 8'h00;

      repeat (2) @(negedge clk);
      chk("rst_tx", int'(txl[0]), 1);
      chk("rst_ready", int'(rdy[0]), 1);
      chk("rst_done", int'(done[0]), 0);
      n_rst = 1'b1;

      send(0, 8'hA5, 1'b0, cap, len);
      chk("a5_bits", int'(cap[9:0]), int'(10'b1101001010));
      chk("a5_len", len, 160);

      send(1, 8'h07, 1'b0, cap, len);
      chk("even_bits", int'(cap[11:0]), int'(12'b111000001110));
      chk("even_par", int'(cap[9]), 1);
      chk("even_len", len, 48);

      send(2, 8'h07, 1'b0, cap, len);
      chk("odd_par", int'(cap[9]), 0);
      chk("odd_len", len, 176);

      // Back-to-back with valid held high.
      @(negedge clk);
      qs = acc_cyc.size();
      valid[0]  = 1'b1;
      data_a[0] = 8'h3C;
      n = 0;
      while (rdy[0] && n < 20) begin @(negedge clk); n++; end
      data_a[0] = 8'hC3;
      n = 0;
      while (!rdy[0] && n < 400) begin @(negedge clk); n++; end
      n = 0;
      while (rdy[0] && n < 20) begin @(negedge clk); n++; end
      valid[0] = 1'b0;
      n = 0;
      while (!done[0] && n < 400) begin @(negedge clk); n++; end
      chk("b2b_done_seen", int'(done[0]), 1);
      if (acc_cyc.size() >= qs + 2)
         chk("b2b_gap", acc_cyc[qs+1] - acc_cyc[qs], 161);
      else
         chk("b2b_accepts", acc_cyc.size() - qs, 2);

      // Valid pulsed while busy is ignored.
      a0 = acc_cnt[0];
      send(0, 8'h96, 1'b1, cap, len);
      chk("busy_bits", int'(cap[9:0]), int'(10'b1100101100));
      chk("busy_len", len, 160);
      repeat (50) @(negedge clk);
      chk("busy_accepts", acc_cnt[0] - a0, 1);
      chk("busy_idle_tx", int'(txl[0]), 1);

      fork
         rnd_run(0);
         rnd_run(1);
         rnd_run(2);
      join

      // Reset in the middle of a frame.
      @(negedge clk);
      valid[0]  = 1'b1;
      data_a[0] = 8'hF0;
      @(negedge clk);
      valid[0] = 1'b0;
      repeat (50) @(negedge clk);
      a0 = acc_cnt[0];
      chk("pre_rst_tx", int'(txl[0]), 0);
      @(posedge clk);
      #3 n_rst = 1'b0;
      #1;
      chk("mid_rst_tx", int'(txl[0]), 1);
      chk("mid_rst_ready", int'(rdy[0]), 1);
      chk("mid_rst_done", int'(done[0]), 0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      repeat (200) @(negedge clk);
      chk("post_rst_accepts", acc_cnt[0] - a0, 0);
      chk("post_rst_tx", int'(txl[0]), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
